// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the xgriscv 5-stage core. It latches the
// decoded instruction fields from ID and detects load-use hazards, inserting
// a bubble when one occurs. It applies operand forwarding from EX/MEM and
// MEM/WB, and it drives the EX-stage ALU operands, the store data and the
// control bits for later stages.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   id_*                decoded fields of the instruction currently in ID
//   exm_regwrite/rd/result   EX/MEM result, used for forwarding
//   wb_regwrite/rd/result    MEM/WB writeback, used for capture-time and
//                            EX-time forwarding
//   flush               taken branch/jump: kill the ID instruction
//   ex_stall            downstream busy: freeze this stage
//   hazard_stall        load-use detected: hold PC and IF/ID this cycle
//   ex_valid            EX slot holds a real instruction
//   ex_pc               PC to the ALU rom_addr (auipc uses it unchanged)
//   ex_a, ex_b          ALU operands (forwarded rs1; imm or forwarded rs2)
//   ex_store_data       forwarded rs2, used by stores whatever alusrc is
//   ex_aluop, ex_rd,
//   ex_regwrite, ex_memread, ex_memwrite   control for EX/MEM/WB
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned XLEN      = 32,
    // Encoding of the core's "add" ALU operation; a bubble carries this value.
    parameter logic [4:0]  NOP_ALUOP = 5'b00000
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_aluop,
    input  logic            id_alusrc_b,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,

    input  logic            exm_regwrite,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,

    input  logic            flush,
    input  logic            ex_stall,

    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_aluop,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite
);

    // What the pipeline register does at the next clock edge.
    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_LOAD
    } upd_e;

    upd_e            upd;

    // Registered fields that are not outputs themselves.
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] ex_imm;
    logic            ex_alusrc_b;

    // Values captured into the rs registers at the edge.
    logic [XLEN-1:0] cap_rs1;
    logic [XLEN-1:0] cap_rs2;

    // Operands after EX-time forwarding.
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // ------------------------------------------------------------------------
    // Load-use hazard: the load in EX cannot forward its data until MEM/WB,
    // so a dependent instruction in ID must wait one cycle. A flush kills the
    // dependent instruction anyway, and a frozen stage cannot take a bubble,
    // so both suppress the stall.
    // ------------------------------------------------------------------------
    always_comb begin
        hazard_stall = 1'b0;
        if (id_valid && ex_valid && ex_memread && (ex_rd != 5'd0) &&
            !flush && !ex_stall) begin
            if ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd))) begin
                hazard_stall = 1'b1;
            end
        end
    end

    // Update selection in priority order: freeze, flush, load-use, load.
    always_comb begin
        upd = UPD_LOAD;
        if (ex_stall) begin
            upd = UPD_HOLD;
        end else if (flush || hazard_stall) begin
            upd = UPD_BUBBLE;
        end
    end

    // ------------------------------------------------------------------------
    // Capture-time forwarding: the register file is written at the same edge
    // this stage captures, so the read port still shows the old value. Take
    // the value being written instead.
    // ------------------------------------------------------------------------
    always_comb begin
        cap_rs1 = id_rs1_data;
        cap_rs2 = id_rs2_data;
        if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs1)) begin
            cap_rs1 = wb_result;
        end
        if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs2)) begin
            cap_rs2 = wb_result;
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_alusrc_b <= 1'b0;
            ex_aluop    <= NOP_ALUOP;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
        end else begin
            case (upd)
                UPD_BUBBLE: begin
                    ex_valid    <= 1'b0;
                    ex_pc       <= '0;
                    ex_rs1      <= '0;
                    ex_rs2      <= '0;
                    ex_rs1_val  <= '0;
                    ex_rs2_val  <= '0;
                    ex_imm      <= '0;
                    ex_alusrc_b <= 1'b0;
                    ex_aluop    <= NOP_ALUOP;
                    ex_rd       <= '0;
                    ex_regwrite <= 1'b0;
                    ex_memread  <= 1'b0;
                    ex_memwrite <= 1'b0;
                end
                UPD_LOAD: begin
                    ex_valid    <= id_valid;
                    ex_pc       <= id_pc;
                    ex_rs1      <= id_rs1;
                    ex_rs2      <= id_rs2;
                    ex_rs1_val  <= cap_rs1;
                    ex_rs2_val  <= cap_rs2;
                    ex_imm      <= id_imm;
                    ex_alusrc_b <= id_alusrc_b;
                    ex_aluop    <= id_aluop;
                    ex_rd       <= id_rd;
                    ex_regwrite <= id_regwrite;
                    ex_memread  <= id_memread;
                    ex_memwrite <= id_memwrite;
                end
                default: begin
                    // UPD_HOLD: every register keeps its value.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // EX-time forwarding. EX/MEM holds the younger result, so it wins over
    // MEM/WB when both target the same register. x0 is never forwarded.
    // While ex_stall holds this stage, the downstream stages are frozen too,
    // so these selections stay stable.
    // ------------------------------------------------------------------------
    always_comb begin
        fwd_rs1 = ex_rs1_val;
        if (exm_regwrite && (exm_rd != 5'd0) && (exm_rd == ex_rs1)) begin
            fwd_rs1 = exm_result;
        end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs1)) begin
            fwd_rs1 = wb_result;
        end
    end

    always_comb begin
        fwd_rs2 = ex_rs2_val;
        if (exm_regwrite && (exm_rd != 5'd0) && (exm_rd == ex_rs2)) begin
            fwd_rs2 = exm_result;
        end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs2)) begin
            fwd_rs2 = wb_result;
        end
    end

    // lui/auipc need nothing special: imm goes out on B and the PC goes out
    // unchanged on ex_pc.
    always_comb begin
        ex_a          = fwd_rs1;
        ex_b          = ex_alusrc_b ? ex_imm : fwd_rs2;
        ex_store_data = fwd_rs2;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Scoreboard bench for id_ex_stage. Each ID-side transaction pushes the EX
// contents it should produce; after the capturing edge the EX-time forwarding
// inputs for that cycle are applied and the entry is popped and compared.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam logic [4:0] NOP = 5'd0;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_aluop;
    logic        id_alusrc_b;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_memwrite;
    logic        exm_regwrite;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        flush;
    logic        ex_stall;
    logic        hazard_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_aluop;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];

    id_ex_stage #(
        .XLEN      (32),
        .NOP_ALUOP (NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_aluop      (id_aluop),
        .id_alusrc_b   (id_alusrc_b),
        .id_regwrite   (id_regwrite),
        .id_memread    (id_memread),
        .id_memwrite   (id_memwrite),
        .exm_regwrite  (exm_regwrite),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .flush         (flush),
        .ex_stall      (ex_stall),
        .hazard_stall  (hazard_stall),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_store_data (ex_store_data),
        .ex_aluop      (ex_aluop),
        .ex_rd         (ex_rd),
        .ex_regwrite   (ex_regwrite),
        .ex_memread    (ex_memread),
        .ex_memwrite   (ex_memwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [31:0] r1d, input logic [31:0] r2d,
                          input logic [31:0] imm, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic [4:0] op,
                          input logic srcb, input logic rw, input logic mr,
                          input logic mw);
        id_valid    = v;
        id_pc       = pc;
        id_rs1_data = r1d;
        id_rs2_data = r2d;
        id_imm      = imm;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_aluop    = op;
        id_alusrc_b = srcb;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = mw;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] erd,
                           input logic [31:0] eres, input logic wrw,
                           input logic [4:0] wrd, input logic [31:0] wres);
        exm_regwrite = erw;
        exm_rd       = erd;
        exm_result   = eres;
        wb_regwrite  = wrw;
        wb_rd        = wrd;
        wb_result    = wres;
    endtask

    task automatic push_exp(input logic v, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] sd, input logic [4:0] op,
                            input logic [4:0] rd, input logic rw,
                            input logic mr, input logic mw);
        exp_t e;
        e.v = v; e.pc = pc; e.a = a; e.b = b; e.sd = sd;
        e.op = op; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
        sb.push_back(e);
    endtask

    task automatic push_bubble();
        push_exp(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, NOP, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic compare_exp(input string tag, input exp_t e);
        check_val({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, e.v});
        check_val({tag, ".pc"}, ex_pc, e.pc);
        check_val({tag, ".a"}, ex_a, e.a);
        check_val({tag, ".b"}, ex_b, e.b);
        check_val({tag, ".store_data"}, ex_store_data, e.sd);
        check_val({tag, ".aluop"}, {27'd0, ex_aluop}, {27'd0, e.op});
        check_val({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
        check_val({tag, ".regwrite"}, {31'd0, ex_regwrite}, {31'd0, e.rw});
        check_val({tag, ".memread"}, {31'd0, ex_memread}, {31'd0, e.mr});
        check_val({tag, ".memwrite"}, {31'd0, ex_memwrite}, {31'd0, e.mw});
    endtask

    // Capture edge, then apply this cycle's EX-time forwarding, then pop
    // the oldest expectation and compare.
    task automatic clock_and_check(input string tag, input logic erw,
                                   input logic [4:0] erd, input logic [31:0] eres,
                                   input logic wrw, input logic [4:0] wrd,
                                   input logic [31:0] wres);
        exp_t e;
        @(posedge clk);
        #1;
        set_fwd(erw, erd, eres, wrw, wrd, wres);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, ".scoreboard_entries"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            compare_exp(tag, e);
        end
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic check_hazard(input string tag, input logic exp);
        #1;
        check_val({tag, ".hazard_stall"}, {31'd0, hazard_stall}, {31'd0, exp});
    endtask

    exp_t bubble_e;

    initial begin
        bubble_e.v = 1'b0; bubble_e.pc = 32'h0; bubble_e.a = 32'h0;
        bubble_e.b = 32'h0; bubble_e.sd = 32'h0; bubble_e.op = NOP;
        bubble_e.rd = 5'd0; bubble_e.rw = 1'b0; bubble_e.mr = 1'b0;
        bubble_e.mw = 1'b0;

        reset    = 1'b1;
        flush    = 1'b0;
        ex_stall = 1'b0;
        set_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
               1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        compare_exp("reset", bubble_e);
        check_hazard("reset", 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // add x3,x1,x2
        set_id(1'b1, 32'h100, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3,
               1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        check_hazard("add", 1'b0);
        push_exp(1'b1, 32'h100, 32'h5, 32'h7, 32'h7, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
        clock_and_check("add", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // sub x4,x3,x1: x3 comes from EX/MEM, not the stale regfile read
        set_id(1'b1, 32'h104, 32'hDEAD, 32'h5, 32'h0, 5'd3, 5'd1, 5'd4,
               1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(1'b1, 32'h104, 32'h10, 32'h5, 32'h5, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0);
        clock_and_check("sub_fwd_exm", 1'b1, 5'd3, 32'h10, 1'b0, 5'd0, 32'h0);

        // EX/MEM and MEM/WB both target x5: EX/MEM wins; B takes imm
        set_id(1'b1, 32'h108, 32'h1111, 32'h0, 32'h20, 5'd5, 5'd0, 5'd8,
               1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(1'b1, 32'h108, 32'hAAAA_0000, 32'h20, 32'h0, 5'd3, 5'd8,
                 1'b1, 1'b0, 1'b0);
        clock_and_check("double_fwd", 1'b1, 5'd5, 32'hAAAA_0000,
                        1'b1, 5'd5, 32'h5555_0000);

        // Capture-time writeback into rs2 (x9); at EX time x0 writes
        // must not be forwarded
        set_id(1'b1, 32'h10C, 32'h0, 32'h1, 32'h0, 5'd0, 5'd9, 5'd10,
               1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        push_exp(1'b1, 32'h10C, 32'h0, 32'h99, 32'h99, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0);
        clock_and_check("capture_fwd_x0", 1'b1, 5'd0, 32'hFFFF,
                        1'b1, 5'd0, 32'hEEEE);

        // lw x6,0(x1)
        set_id(1'b1, 32'h110, 32'h1000, 32'h0, 32'h0, 5'd1, 5'd0, 5'd6,
               1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(1'b1, 32'h110, 32'h1000, 32'h0, 32'h0, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0);
        clock_and_check("lw_x6", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // addi x7,x6,4: one bubble, then entry with rs1 from MEM/WB
        set_id(1'b1, 32'h114, 32'h0, 32'h0, 32'h4, 5'd6, 5'd0, 5'd7,
               1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        check_hazard("load_use", 1'b1);
        push_bubble();
        clock_and_check("load_use_bubble", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_hazard("after_bubble", 1'b0);
        push_exp(1'b1, 32'h114, 32'hCAFE, 32'h4, 32'h0, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
        clock_and_check("addi_after_bubble", 1'b0, 5'd0, 32'h0,
                        1'b1, 5'd6, 32'hCAFE);

        // Load to x0 followed by a reader of x0: no hazard
        set_id(1'b1, 32'h118, 32'h2000, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0,
               1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(1'b1, 32'h118, 32'h2000, 32'h0, 32'h0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
        clock_and_check("lw_x0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 32'h11C, 32'h0, 32'h0, 32'h4, 5'd0, 5'd0, 5'd11,
               1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        check_hazard("load_use_x0", 1'b0);
        push_exp(1'b1, 32'h11C, 32'h0, 32'h4, 32'h0, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0);
        clock_and_check("use_x0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Flush together with a load-use condition: bubble, no stall
        set_id(1'b1, 32'h120, 32'h3000, 32'h0, 32'h8, 5'd1, 5'd0, 5'd6,
               1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(1'b1, 32'h120, 32'h3000, 32'h8, 32'h0, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0);
        clock_and_check("lw_x6_again", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 32'h124, 32'h0, 32'h0, 32'h4, 5'd6, 5'd0, 5'd7,
               1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        check_hazard("flush_and_hazard", 1'b0);
        push_bubble();
        clock_and_check("flush_bubble", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        flush = 1'b0;

        // Store enters, then ex_stall with flush holds it unchanged
        set_id(1'b1, 32'h128, 32'h77, 32'h88, 32'h0, 5'd12, 5'd13, 5'd14,
               1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(1'b1, 32'h128, 32'h77, 32'h88, 32'h88, 5'd5, 5'd14, 1'b0, 1'b0, 1'b1);
        clock_and_check("store", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 32'h12C, 32'h1, 32'h2, 32'h0, 5'd15, 5'd16, 5'd17,
               1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        flush    = 1'b1;
        ex_stall = 1'b1;
        check_hazard("stall_flush", 1'b0);
        push_exp(1'b1, 32'h128, 32'h77, 32'h88, 32'h88, 5'd5, 5'd14, 1'b0, 1'b0, 1'b1);
        clock_and_check("stall_hold", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        flush    = 1'b0;
        ex_stall = 1'b0;

        // id_valid=0 loads fields but ex_valid follows id_valid
        set_id(1'b0, 32'h130, 32'h9, 32'hA, 32'hB, 5'd1, 5'd2, 5'd18,
               1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        check_hazard("invalid_id", 1'b0);
        push_exp(1'b0, 32'h130, 32'h9, 32'hB, 32'hA, 5'd7, 5'd18, 1'b1, 1'b0, 1'b0);
        clock_and_check("invalid_id", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Asynchronous reset between edges
        #1;
        reset = 1'b1;
        #1;
        compare_exp("async_reset", bubble_e);
        check_hazard("async_reset", 1'b0);

        check_val("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the xgriscv 5-stage core; sits directly upstream of the EX-stage ALU.
- Latches decoded fields from ID and detects load-use hazards, inserting bubbles on them.
- Applies operand forwarding from EX/MEM and MEM/WB.
- Produces the ALU operands A, B, ALUOp and PC (rom_addr), plus store data and control for later stages.

Parameters:
XLEN, 32, datapath width
NOP_ALUOP, `ALUOp_add, ALUOp value loaded on a bubble

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_pc  input  32  PC of ID instruction
id_rs1_data  input  32  register file read port 1
id_rs2_data  input  32  register file read port 2
id_imm  input  32  sign-extended/shifted immediate
id_rs1  input  5  source register index 1
id_rs2  input  5  source register index 2
id_rd  input  5  destination register index
id_use_rs1  input  1  instruction reads rs1
id_use_rs2  input  1  instruction reads rs2
id_aluop  input  5  ALU operation code
id_alusrc_b  input  1  1: B=imm, 0: B=rs2
id_regwrite  input  1  writes rd
id_memread  input  1  load
id_memwrite  input  1  store
exm_regwrite  input  1  EX/MEM instruction writes rd
exm_rd  input  5  EX/MEM destination
exm_result  input  32  EX/MEM ALU result
wb_regwrite  input  1  MEM/WB instruction writes rd
wb_rd  input  5  MEM/WB destination
wb_result  input  32  MEM/WB writeback value
flush  input  1  branch/jump taken: kill ID instruction
ex_stall  input  1  downstream busy: freeze this stage
hazard_stall  output  1  hold PC and IF/ID this cycle
ex_valid  output  1  EX slot holds a real instruction
ex_pc  output  32  to ALU rom_addr
ex_a  output  32  ALU operand A (forwarded rs1)
ex_b  output  32  ALU operand B (imm or forwarded rs2)
ex_store_data  output  32  forwarded rs2 for stores
ex_aluop  output  5  to ALU ALUOp
ex_rd  output  5  destination
ex_regwrite, ex_memread, ex_memwrite  output  1 each  control

Behaviour:
- Reset (async, immediate): all registered fields are zero, ex_aluop=NOP_ALUOP, and ex_valid is 0; hazard_stall is driven 0.
- hazard_stall (comb) = id_valid & ex_valid & ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) & !flush & !ex_stall.
- Per-edge update, in priority order:
  - ex_stall=1: hold all registers; flush is ignored that cycle, and the source must keep flush asserted.
  - flush=1: load a bubble.
  - hazard_stall=1: load a bubble.
  - Otherwise: load the ID fields, with ex_valid = id_valid.
- Bubble: valid, regwrite, memread and memwrite are 0; aluop=NOP_ALUOP; rd=0; other fields are don't-care, driven 0.
- Capture-time forwarding covers a same-cycle regfile write. If wb_regwrite & wb_rd!=0 & wb_rd==id_rsN, the rsN register latches wb_result instead of id_rsN_data.
- EX-time forwarding (comb, on the registered rs1/rs2 value, per operand N):
  - First priority: exm_regwrite & exm_rd!=0 & exm_rd==ex_rsN selects exm_result.
  - Else wb_regwrite & wb_rd!=0 & wb_rd==ex_rsN selects wb_result.
  - Else the latched value is used.
  - Index 0 is never forwarded; ex_rs1/ex_rs2 are internal registers.
- ex_a = fwd_rs1.
- ex_b = id_alusrc_b (registered) ? imm : fwd_rs2.
- ex_store_data = fwd_rs2 regardless of alusrc.
- lui/auipc: ALU consumes B and rom_addr; this block passes imm in B and the PC in ex_pc unchanged.
- Latency: one cycle ID->EX; a load-use adds exactly one bubble.
- Forwarding during ex_stall: downstream stages are frozen too, so the forwarded values stay stable.

Test Plan:
- Reset mid-stream with reset=1 asynchronous between edges -> outputs zero and ex_aluop=NOP_ALUOP immediately, without waiting for a clock edge; ex_valid=0.
- `add x3,x1,x2` then `sub x4,x3,x1` with exm_result=0x0000_0010 -> for sub, ex_a=0x10 from EX/MEM, not the stale regfile value.
- Double hazard: EX/MEM and MEM/WB both target x5 (0xAAAA_0000 vs 0x5555_0000) -> ex_a=0xAAAA_0000.
- `lw x6,0(x1)` then `addi x7,x6,4` -> hazard_stall=1 for one cycle and a bubble enters EX (ex_valid=0, ex_regwrite=0); next cycle addi enters with rs1 forwarded from wb_result.
- Same load-use with rd=x0 -> hazard_stall stays 0, no bubble.
- flush and hazard_stall conditions together -> bubble, hazard_stall=0. ex_stall=1 together with flush=1 -> EX contents unchanged across the edge.
